// File: rtl/uart_tx_frame_ctrl_pkg.sv
// Shared definitions for the UART TX framing controller: state encodings and line/parity constants.
package uart_tx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_STOP2  = 3'd5
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator: even parity is the XOR of all payload bits, odd is its inverse.
module uart_tx_parity_calc
    import uart_tx_frame_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_parity
);

    logic w_xor;

    assign w_xor = ^i_data;

    always_comb begin
        o_parity = w_xor;
        case (i_par_typ)
            PAR_EVEN: o_parity = w_xor;
            PAR_ODD:  o_parity = ~w_xor;
            default:  o_parity = w_xor;
        endcase
    end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX framing controller: latches a byte, sequences START/DATA/PARITY/STOP and muxes the TX line.
// Optional second stop bit with `define UART_TX_TWO_STOP_EN.
module uart_tx_frame_ctrl
    import uart_tx_frame_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic [DATA_WIDTH-1:0] ser_p_data,
    output logic                  tx_out,
    output logic                  busy
);

    tx_state_e             r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_bit;

    logic                  w_capture;
    logic [DATA_WIDTH-1:0] w_calc_data;
    logic                  w_calc_typ;
    logic                  w_parity;
    logic                  w_tx;

    assign w_capture = (r_state == ST_IDLE) && data_valid;

    // Parity follows the held byte between captures, so it always matches ser_p_data.
    assign w_calc_data = w_capture ? p_data  : r_data;
    assign w_calc_typ  = w_capture ? par_typ : r_par_typ;

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .i_data    (w_calc_data),
        .i_par_typ (w_calc_typ),
        .o_parity  (w_parity)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_par_bit <= 1'b0;
        end else begin
            r_par_bit <= w_parity;
            case (r_state)
                ST_IDLE: begin
                    if (data_valid) begin
                        r_data    <= p_data;
                        r_par_en  <= par_en;
                        r_par_typ <= par_typ;
                        r_state   <= ST_START;
                    end
                end
                ST_START: r_state <= ST_DATA;
                // ser_done already high on entry still exits after one cycle.
                ST_DATA: begin
                    if (ser_done)
                        r_state <= r_par_en ? ST_PARITY : ST_STOP;
                end
                ST_PARITY: r_state <= ST_STOP;
`ifdef UART_TX_TWO_STOP_EN
                ST_STOP:  r_state <= ST_STOP2;
                ST_STOP2: r_state <= ST_IDLE;
`else
                ST_STOP:  r_state <= ST_IDLE;
`endif
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_tx = STOP_BIT;
        case (r_state)
            ST_START:  w_tx = START_BIT;
            ST_DATA:   w_tx = ser_data;
            ST_PARITY: w_tx = r_par_bit;
            default:   w_tx = STOP_BIT;
        endcase
    end

    assign tx_out     = w_tx;
    assign busy       = (r_state != ST_IDLE);
    assign ser_en     = (r_state == ST_START);
    assign ser_p_data = r_data;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: serializer model, frame-level reference queue, directed and random frames.
module tb_uart_tx_frame_ctrl;

    localparam int W = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int EX = 1;
    localparam logic [15:0] L_A5E = 16'b110101001010;
    localparam logic [15:0] L_A5O = 16'b111101001010;
    localparam logic [15:0] L_A5N = 16'b11101001010;
    localparam logic [15:0] L_FFE = 16'b110111111110;
    localparam logic [15:0] L_5AE = 16'b110010110100;
    localparam logic [15:0] L_FLT = 16'b11010;
`else
    localparam int EX = 0;
    localparam logic [15:0] L_A5E = 16'b10101001010;
    localparam logic [15:0] L_A5O = 16'b11101001010;
    localparam logic [15:0] L_A5N = 16'b1101001010;
    localparam logic [15:0] L_FFE = 16'b10111111110;
    localparam logic [15:0] L_5AE = 16'b10010110100;
    localparam logic [15:0] L_FLT = 16'b1010;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] p_data = '0;
    logic         data_valid = 1'b0;
    logic         par_en = 1'b0;
    logic         par_typ = 1'b0;
    logic         ser_data;
    logic         ser_done;
    logic         ser_en;
    logic [W-1:0] ser_p_data;
    logic         tx_out;
    logic         busy;
    logic         fault_done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_frame_ctrl #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .ser_p_data (ser_p_data),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    // Serializer: loads on ser_en, shifts LSB first, done when its counter is zero.
    logic [W-1:0] s_sh;
    logic [3:0]   s_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_sh  <= '0;
            s_cnt <= '0;
        end else if (ser_en) begin
            s_sh  <= ser_p_data;
            s_cnt <= 4'(W - 1);
        end else if (s_cnt != 0) begin
            s_sh  <= s_sh >> 1;
            s_cnt <= s_cnt - 4'd1;
        end
    end
    assign ser_data = s_sh[0];
    assign ser_done = fault_done | (s_cnt == 0);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected line bits of one frame, index 0 = first cycle after acceptance.
    function automatic void build(input logic [W-1:0] d, input logic pe, input logic pt,
                                  input logic f, output logic [15:0] s, output int n);
        s = '0;
        n = 0;
        s[n] = 1'b0; n++;
        for (int i = 0; i < (f ? 1 : W); i++) begin
            s[n] = d[i]; n++;
        end
        if (pe) begin
            s[n] = (^d) ^ pt; n++;
        end
        for (int i = 0; i < 1 + EX; i++) begin
            s[n] = 1'b1; n++;
        end
    endfunction

    typedef struct {
        logic         tx;
        logic         sen;
        logic [W-1:0] d;
    } exp_t;
    exp_t q[$];

    always @(posedge clk or negedge rst) begin : model
        logic [15:0] s;
        int          n;
        bit          was_idle;
        if (!rst) begin
            q.delete();
        end else begin
            was_idle = (q.size() == 0);
            if (!was_idle) q.delete(0);
            if (was_idle && data_valid) begin
                build(p_data, par_en, par_typ, fault_done, s, n);
                for (int i = 0; i < n; i++) q.push_back('{tx: s[i], sen: (i == 0), d: p_data});
            end
        end
    end

    always @(negedge clk) begin
        if (q.size() != 0) begin
            chk("tx_out", 32'(tx_out), 32'(q[0].tx));
            chk("busy", 32'(busy), 32'd1);
            chk("ser_en", 32'(ser_en), 32'(q[0].sen));
            chk("ser_p_data", 32'(ser_p_data), 32'(q[0].d));
        end else begin
            chk("tx_idle", 32'(tx_out), 32'd1);
            chk("busy_idle", 32'(busy), 32'd0);
            chk("ser_en_idle", 32'(ser_en), 32'd0);
        end
    end

    task automatic run_frame(input logic [W-1:0] d, input logic pe, input logic pt, input int inj,
                             output logic [15:0] seq, output int len);
        @(negedge clk);
        p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        seq = '0;
        len = 0;
        while (busy && len < 16) begin
            seq[len] = tx_out;
            len++;
            if (len == inj) begin
                p_data = 8'h3C; par_en = ~pe; par_typ = ~pt; data_valid = 1'b1;
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
    endtask

    logic [15:0] seq, ms;
    int          len, mn, len1, gap;

    initial begin
        #1;
        chk("rst_tx", 32'(tx_out), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ser_en", 32'(ser_en), 32'd0);
        chk("rst_ser_p_data", 32'(ser_p_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        build(8'hA5, 1'b1, 1'b0, 1'b0, ms, mn);
        chk("model_a5_even", 32'(ms), 32'(L_A5E));
        chk("model_a5_len", 32'(mn), 32'(11 + EX));

        run_frame(8'hA5, 1'b1, 1'b0, 0, seq, len);
        chk("a5_even_seq", 32'(seq), 32'(L_A5E));
        chk("a5_even_len", 32'(len), 32'(11 + EX));
        run_frame(8'hA5, 1'b1, 1'b1, 0, seq, len);
        chk("a5_odd_seq", 32'(seq), 32'(L_A5O));
        run_frame(8'hA5, 1'b0, 1'b0, 0, seq, len);
        chk("a5_nopar_seq", 32'(seq), 32'(L_A5N));
        chk("a5_nopar_len", 32'(len), 32'(10 + EX));
        run_frame(8'h5A, 1'b1, 1'b0, 0, seq, len);
        chk("5a_seq", 32'(seq), 32'(L_5AE));
        chk("5a_len", 32'(len), 32'(11 + EX));

        // Mid-frame input changes and a request during DATA must not leak.
        run_frame(8'hA5, 1'b1, 1'b0, 4, seq, len);
        chk("a5_inj_seq", 32'(seq), 32'(L_A5E));
        for (int i = 0; i < 3; i++) begin
            chk("no_3C", 32'(busy), 32'd0);
            @(negedge clk);
        end

        // Back-to-back with data_valid held high.
        p_data = 8'h00; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
        @(negedge clk);
        p_data = 8'hFF;
        len1 = 0;
        while (busy && len1 < 16) begin len1++; @(negedge clk); end
        gap = 0;
        while (!busy && gap < 5) begin
            chk("gap_tx", 32'(tx_out), 32'd1);
            gap++;
            @(negedge clk);
        end
        data_valid = 1'b0;
        seq = '0;
        len = 0;
        while (busy && len < 16) begin seq[len] = tx_out; len++; @(negedge clk); end
        chk("b2b_len1", 32'(len1), 32'(11 + EX));
        chk("b2b_gap", 32'(gap), 32'd1);
        chk("b2b_ff_seq", 32'(seq), 32'(L_FFE));
        chk("b2b_ff_len", 32'(len), 32'(11 + EX));
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of DATA.
        p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx_out), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ser_en", 32'(ser_en), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_frame(8'hA5, 1'b1, 1'b0, 0, seq, len);
        chk("post_rst_seq", 32'(seq), 32'(L_A5E));

        // Serializer reporting done on DATA entry.
        @(negedge clk);
        fault_done = 1'b1;
        run_frame(8'hA5, 1'b1, 1'b0, 0, seq, len);
        chk("fault_seq", 32'(seq), 32'(L_FLT));
        chk("fault_len", 32'(len), 32'(4 + EX));
        fault_done = 1'b0;
        repeat (10) @(negedge clk);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            data_valid = ($urandom_range(0, 3) == 0);
            p_data     = 8'($urandom);
            par_en     = 1'($urandom);
            par_typ    = 1'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end
        data_valid = 1'b0;
        repeat (16) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
